// File: rtl/ofmaps_pkg.sv
// Shared constants and configuration helpers for the ofmaps AXIS packer slice.
package ofmaps_pkg;

    localparam int unsigned MAC_OUT_W = 5;
    localparam int unsigned LANE_W    = 8;

    function automatic bit cfg_ok(int unsigned mac_num, int unsigned data_width);
        if (data_width < LANE_W || (data_width % LANE_W) != 0) return 1'b0;
        return (mac_num > 0) && ((mac_num % (data_width / LANE_W)) == 0);
    endfunction

    function automatic int unsigned cnt_width(int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ofmaps_beat_mux.sv
// Selects one beat of a stored MAC vector and zero-extends each element into its lane.
module ofmaps_beat_mux
    import ofmaps_pkg::*;
#(
    parameter int unsigned MAC_NUM    = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 5
) (
    input  logic [MAC_OUT_W*MAC_NUM-1:0] buf_data,
    input  logic [CNT_W-1:0]             beat_cnt,
    output logic [DATA_WIDTH-1:0]        tdata
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;

    always_comb begin
        tdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tdata[i*LANE_W +: LANE_W] = {{(LANE_W-MAC_OUT_W){1'b0}},
                buf_data[(32'(beat_cnt)*LANES + i)*MAC_OUT_W +: MAC_OUT_W]};
        end
    end

endmodule

// File: rtl/ofmaps_axis_packer.sv
// Ping-pong capture of MAC output vectors and lane-packed AXI4-Stream serialization.
module ofmaps_axis_packer
    import ofmaps_pkg::*;
#(
    parameter int unsigned MAC_NUM    = 256,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAC_OUT_W*MAC_NUM-1:0] mac_out,
    input  logic                         mac_o_valid,
    output logic                         pack_ready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         overflow,
    input  logic                         overflow_clr,
    output logic [1:0]                   buf_level
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;
    localparam int unsigned BEATS = MAC_NUM / LANES;
    localparam int unsigned CNT_W = cnt_width(BEATS);
    localparam int unsigned VEC_W = MAC_OUT_W * MAC_NUM;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (!cfg_ok(MAC_NUM, DATA_WIDTH)) begin : g_bad_cfg
            $error("ofmaps_axis_packer: MAC_NUM must be a multiple of DATA_WIDTH/8");
        end
    endgenerate

    logic [VEC_W-1:0] buf_q [2];
    logic [VEC_W-1:0] rd_data;
    logic             wr_sel;
    logic             rd_sel;
    logic [1:0]       level;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_hs;
    logic             last_hs;
    logic             accept;

    always_comb begin
        m_axis_tvalid = (level != 2'd0);
        m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_BEAT);
        beat_hs       = m_axis_tvalid && m_axis_tready;
        last_hs       = beat_hs && m_axis_tlast;
        // A full pair may still take a vector when the older one frees this same edge.
        accept        = mac_o_valid && ((level != 2'd2) || last_hs);
        pack_ready    = (level != 2'd2);
        buf_level     = level;
        rd_data       = buf_q[rd_sel];
    end

    ofmaps_beat_mux #(
        .MAC_NUM    (MAC_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_beat_mux (
        .buf_data (rd_data),
        .beat_cnt (beat_cnt),
        .tdata    (m_axis_tdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (accept) begin
            buf_q[wr_sel] <= mac_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            level    <= 2'd0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_sel <= ~wr_sel;
            if (beat_hs) begin
                if (last_hs) begin
                    beat_cnt <= '0;
                    rd_sel   <= ~rd_sel;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            case ({accept, last_hs})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
            if (mac_o_valid && !accept) overflow <= 1'b1;
            else if (overflow_clr)      overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofmaps_axis_packer.sv
// Randomized self-checking bench for ofmaps_axis_packer against a queue-based vector model.
module tb_ofmaps_axis_packer;

    localparam int unsigned MAC_NUM    = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BEATS      = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] mac_out;
    logic        mac_o_valid;
    logic        pack_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overflow;
    logic        overflow_clr;
    logic [1:0]  buf_level;

    int checks = 0;
    int errors = 0;

    logic [39:0] mq[$];
    int unsigned m_beat = 0;
    bit          m_ovf  = 1'b0;

    always #5 clk = ~clk;

    ofmaps_axis_packer #(
        .MAC_NUM    (MAC_NUM),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mac_out       (mac_out),
        .mac_o_valid   (mac_o_valid),
        .pack_ready    (pack_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .buf_level     (buf_level)
    );

    function automatic logic [31:0] beat_word(logic [39:0] v, int unsigned b);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) begin
            int unsigned k = b * 4 + i;
            logic [39:0] e = (v >> (5 * k)) & 40'h1f;
            w = w | (e[31:0] << (8 * i));
        end
        return w;
    endfunction

    function automatic logic [37:0] exp_bundle();
        bit          v = (mq.size() != 0);
        logic [31:0] w = 32'h0;
        if (v) w = beat_word(mq[0], m_beat);
        return {v, v && (m_beat == BEATS - 1), w, 2'(mq.size()), mq.size() < 2, m_ovf};
    endfunction

    function automatic logic [37:0] obs_bundle();
        return {m_axis_tvalid, m_axis_tlast, (mq.size() != 0) ? m_axis_tdata : 32'h0,
                buf_level, pack_ready, overflow};
    endfunction

    function automatic logic [39:0] rand_vec();
        return {$urandom_range(255, 0), $urandom()};
    endfunction

    // Advance one clock: model consumes the inputs that the DUT will see at the edge.
    task automatic tick();
        bit v, hs, last, acc;
        @(negedge clk);
        if (rst) begin
            mq.delete();
            m_beat = 0;
            m_ovf  = 1'b0;
        end else begin
            v    = (mq.size() != 0);
            hs   = v && m_axis_tready;
            last = hs && (m_beat == BEATS - 1);
            acc  = mac_o_valid && ((mq.size() < 2) || last);
            if (hs) begin
                if (last) begin
                    void'(mq.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (acc) mq.push_back(mac_out);
            if (mac_o_valid && !acc) m_ovf = 1'b1;
            else if (overflow_clr)   m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mac_o_valid = 1'b0; mac_out = '0; m_axis_tready = 1'b0; overflow_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({obs_bundle(), m_axis_tdata} !== {38'h0_0000_0002, 32'h0}) begin
            errors++;
            $display("FAIL reset_init: got %h/%h expected %h/0", obs_bundle(), m_axis_tdata, 38'h2);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mac_o_valid = 1'b1; mac_out = rand_vec(); m_axis_tready = 1'b0;
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL reset_fill c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
        end
        mac_o_valid = 1'b0;
        rst = 1'b1;
        mq.delete(); m_beat = 0; m_ovf = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, buf_level, pack_ready, overflow}
                !== {1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got v%b l%b d%h lvl%0d r%b o%b expected 0 0 0 0 1 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, buf_level, pack_ready, overflow);
        end
        tick();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || obs_bundle() !== exp_bundle()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_single();
        logic [39:0] v = '0;
        for (int k = 0; k < 8; k++) v[5*k +: 5] = 5'(k + 1);
        m_axis_tready = 1'b1;
        mac_out = v; mac_o_valid = 1'b1;
        tick();
        mac_o_valid = 1'b0;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, 32'h04030201}) begin
            errors++;
            $display("FAIL single_beat0: got v%b l%b %h expected v1 l0 04030201",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, 32'h08070605}) begin
            errors++;
            $display("FAIL single_beat1: got v%b l%b %h expected v1 l1 08070605",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || obs_bundle() !== exp_bundle()) begin
            errors++;
            $display("FAIL single_done: got %h expected %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_backpressure();
        bit rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int hs = 0;
        m_axis_tready = 1'b0;
        mac_out = rand_vec(); mac_o_valid = 1'b1;
        tick();
        mac_o_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            m_axis_tready = (c < 4) ? rdy[c] : 1'b1;
            if (m_axis_tvalid && m_axis_tready) hs++;
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL backpressure c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
        end
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL backpressure_beats: got %0d expected 2", hs);
        end
    endtask

    task automatic test_ping_pong();
        int unsigned maxlvl = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mac_o_valid = (c == 0 || c == 2);
            mac_out = rand_vec();
            tick();
            if (buf_level > maxlvl) maxlvl = buf_level;
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL ping_pong c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
        end
        mac_o_valid = 1'b0;
        checks++;
        if (overflow !== 1'b0 || maxlvl > 2) begin
            errors++;
            $display("FAIL ping_pong_ovf: got ovf %b maxlvl %0d expected ovf 0", overflow, maxlvl);
        end
    endtask

    task automatic test_overflow();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mac_out = rand_vec(); mac_o_valid = 1'b1;
            tick();
        end
        mac_o_valid = 1'b0;
        checks++;
        if ({overflow, buf_level, pack_ready} !== {1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL overflow_set: got o%b lvl%0d r%b expected o1 lvl2 r0",
                     overflow, buf_level, pack_ready);
        end
        m_axis_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL overflow_drain c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr: got %b expected 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        m_axis_tready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mac_out = rand_vec(); mac_o_valid = 1'b1;
            tick();
        end
        mac_o_valid = 1'b0; m_axis_tready = 1'b1;
        tick();
        mac_out = rand_vec(); mac_o_valid = 1'b1;
        tick();
        mac_o_valid = 1'b0;
        checks++;
        if ({overflow, buf_level} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL simult_accept: got o%b lvl%0d expected o0 lvl2", overflow, buf_level);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL simult_drain c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            mac_o_valid   = ($urandom_range(2, 0) == 0);
            mac_out       = rand_vec();
            m_axis_tready = ($urandom_range(3, 0) != 0);
            overflow_clr  = ($urandom_range(15, 0) == 0);
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL random c%0d: got %h expected %h", c, obs_bundle(), exp_bundle());
            end
        end
        mac_o_valid = 1'b0; overflow_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mac_o_valid = 1'b0; mac_out = '0; m_axis_tready = 1'b0; overflow_clr = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_ping_pong();
        test_overflow();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
